// File: rtl/rv32_lsu_pkg.sv
// Shared definitions for the RV32I load/store sequencer: funct3 encodings, FSM states and
// the access-size helpers.
package rv32_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {IDLE, SECOND} lsu_state_t;

  function automatic logic [3:0] size_mask(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [1:0] size_minus_one(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  // Unsigned variants exist only for loads.
  function automatic logic funct3_ok(input logic [2:0] funct3, input logic is_store);
    case (funct3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !is_store;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane alignment: builds the two-word write mask/data for a store and extracts and
// extends load data from a two-word read window.
module lsu_lane_align
  import rv32_lsu_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  input  logic [63:0] rdata64,
  output logic [7:0]  mask8,
  output logic [63:0] wd64,
  output logic [31:0] ldata
);

  logic [4:0]  sh;
  logic [31:0] v32;

  assign sh    = {off, 3'b000};
  assign mask8 = {4'b0000, size_mask(funct3)} << off;
  assign wd64  = {32'h0, wdata} << sh;
  assign v32   = 32'(rdata64 >> sh);

  always_comb begin
    ldata = 32'h0;
    case (funct3)
      F3_B:    ldata = {{24{v32[7]}}, v32[7:0]};
      F3_H:    ldata = {{16{v32[15]}}, v32[15:0]};
      F3_W:    ldata = v32;
      F3_BU:   ldata = {24'h0, v32[7:0]};
      F3_HU:   ldata = {16'h0, v32[15:0]};
      default: ldata = 32'h0;
    endcase
  end

endmodule

// File: rtl/dmem_lsu_ctrl.sv
// Load/store sequencer between the MEM stage and a byte-lane data memory; splits
// word-crossing accesses into two memory cycles and registers the formatted response.
module dmem_lsu_ctrl
  import rv32_lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES        = 128,
  parameter bit          ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] daddr,
  output logic [31:0] dwdata,
  output logic [3:0]  we,
  input  logic [31:0] drdata
);

  lsu_state_t  state_q, state_d;

  logic [31:0] addr2_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [3:0]  we2_q;
  logic [31:0] wd2_q;
  logic        store_q;
  logic [31:0] lo_q;

  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  logic        latch_en;
  logic        lo_en;

  logic [1:0]  al_off;
  logic [2:0]  al_f3;
  logic [63:0] al_rdata64;
  logic [7:0]  mask8;
  logic [63:0] wd64;
  logic [31:0] ldata;

  logic [31:0] word_addr;
  logic [32:0] last_byte;
  logic        misal;
  logic        range_err;
  logic        bad;

  // In SECOND the aligner sees the latched request and the {hi, lo} read window.
  assign al_off     = (state_q == SECOND) ? off_q : req_addr[1:0];
  assign al_f3      = (state_q == SECOND) ? f3_q  : req_funct3;
  assign al_rdata64 = (state_q == SECOND) ? {drdata, lo_q} : {32'h0, drdata};

  lsu_lane_align u_align (
    .off     (al_off),
    .funct3  (al_f3),
    .wdata   (req_wdata),
    .rdata64 (al_rdata64),
    .mask8   (mask8),
    .wd64    (wd64),
    .ldata   (ldata)
  );

  assign word_addr = {req_addr[31:2], 2'b00};
  // 33-bit sum so addresses near 2^32 cannot wrap back into range.
  assign last_byte = {1'b0, req_addr} + {31'h0, size_minus_one(req_funct3)};
  assign range_err = last_byte >= 33'(MEM_BYTES);
  assign misal     = |mask8[7:4];
  assign bad       = !funct3_ok(req_funct3, req_we) || range_err ||
                     (misal && !ALLOW_MISALIGNED);

  always_comb begin
    state_d     = state_q;
    req_ready   = 1'b0;
    daddr       = 32'h0;
    dwdata      = 32'h0;
    we          = 4'h0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    latch_en    = 1'b0;
    lo_en       = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          daddr  = word_addr;
          dwdata = wd64[31:0];
          we     = (req_we && !bad) ? mask8[3:0] : 4'h0;
          lo_en  = !req_we && !bad;
          if (bad) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'h0;
          end else if (misal) begin
            state_d  = SECOND;
            latch_en = 1'b1;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = req_we ? 32'h0 : ldata;
          end
        end
      end
      SECOND: begin
        daddr       = addr2_q;
        dwdata      = wd2_q;
        we          = we2_q;
        state_d     = IDLE;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = store_q ? 32'h0 : ldata;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr2_q     <= 32'h0;
      f3_q        <= 3'h0;
      off_q       <= 2'h0;
      we2_q       <= 4'h0;
      wd2_q       <= 32'h0;
      store_q     <= 1'b0;
      lo_q        <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      if (lo_en) begin
        lo_q <= drdata;
      end
      if (latch_en) begin
        addr2_q <= word_addr + 32'd4;
        f3_q    <= req_funct3;
        off_q   <= req_addr[1:0];
        we2_q   <= req_we ? mask8[7:4] : 4'h0;
        wd2_q   <= wd64[63:32];
        store_q <= req_we;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// Scoreboard bench for dmem_lsu_ctrl: a byte memory model, directed load/store vectors and
// a negedge monitor comparing each response against the queued expectation and latency.
module tb_dmem_lsu_ctrl;
  import rv32_lsu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata, daddr, dwdata, drdata;
  logic [3:0]  we;

  logic        b_req_valid, b_req_ready, b_req_we;
  logic [2:0]  b_req_funct3;
  logic [31:0] b_req_addr, b_req_wdata;
  logic        b_rsp_valid, b_rsp_err;
  logic [31:0] b_rsp_rdata, b_daddr, b_dwdata, b_drdata;
  logic [3:0]  b_we;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          due;
    string       name;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic [7:0] mem [0:127];

  dmem_lsu_ctrl #(.MEM_BYTES(128), .ALLOW_MISALIGNED(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .daddr(daddr), .dwdata(dwdata), .we(we), .drdata(drdata)
  );

  dmem_lsu_ctrl #(.MEM_BYTES(128), .ALLOW_MISALIGNED(1'b0)) dut_strict (
    .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_we(b_req_we), .req_funct3(b_req_funct3), .req_addr(b_req_addr),
    .req_wdata(b_req_wdata), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
    .rsp_err(b_rsp_err), .daddr(b_daddr), .dwdata(b_dwdata), .we(b_we), .drdata(b_drdata)
  );

  assign b_drdata = 32'h8001_0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    return (a < 32'd128) ? mem[a[6:0]] : 8'h00;
  endfunction

  assign drdata = {rd_byte(daddr + 32'd3), rd_byte(daddr + 32'd2),
                   rd_byte(daddr + 32'd1), rd_byte(daddr)};

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i] && (daddr + 32'(i)) < 32'd128) mem[daddr[6:0] + 7'(i)] <= dwdata[8*i +: 8];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (q_a.size() == 0) begin
        check("a_unexpected_rsp", 32'(rsp_valid), 32'h0);
      end else begin
        exp_t e;
        e = q_a.pop_front();
        check({e.name, "_err"}, 32'(rsp_err), 32'(e.err));
        check({e.name, "_rdata"}, rsp_rdata, e.rdata);
        check({e.name, "_latency"}, 32'(cyc), 32'(e.due));
      end
    end
  end

  always @(negedge clk) begin
    if (b_rsp_valid === 1'b1) begin
      if (q_b.size() == 0) begin
        check("b_unexpected_rsp", 32'(b_rsp_valid), 32'h0);
      end else begin
        exp_t e;
        e = q_b.pop_front();
        check({e.name, "_err"}, 32'(b_rsp_err), 32'(e.err));
        check({e.name, "_rdata"}, b_rsp_rdata, e.rdata);
        check({e.name, "_latency"}, 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic drive(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    req_valid = 1'b1; req_we = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
  endtask

  task automatic idle();
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'h0; req_addr = 32'h0; req_wdata = 32'h0;
  endtask

  task automatic b_idle();
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_funct3 = 3'h0;
    b_req_addr = 32'h0; b_req_wdata = 32'h0;
  endtask

  task automatic expect_a(input string n, input logic e, input logic [31:0] d, input int lat);
    exp_t x;
    x.err = e; x.rdata = d; x.due = cyc + lat; x.name = n;
    q_a.push_back(x);
  endtask

  task automatic expect_b(input string n, input logic e, input logic [31:0] d, input int lat);
    exp_t x;
    x.err = e; x.rdata = d; x.due = cyc + lat; x.name = n;
    q_b.push_back(x);
  endtask

  // One request on the main instance; returns at the negedge it is ready for the next one.
  task automatic op(input string n, input logic w, input logic [2:0] f3,
                    input logic [31:0] a, input logic [31:0] wd,
                    input logic e, input logic [31:0] d, input int lat);
    drive(w, f3, a, wd);
    expect_a(n, e, d, lat);
    @(negedge clk);
    idle();
    if (lat == 2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle();
    b_idle();
    repeat (2) @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_err", 32'(rsp_err), 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_req_ready", 32'(req_ready), 32'h1);
    check("rst_we", 32'(we), 32'h0);
    check("rst_daddr", daddr, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Aligned word store, phase 1 visible in the accept cycle.
    drive(1'b1, F3_W, 32'h10, 32'hDEAD_BEEF);
    expect_a("sw10", 1'b0, 32'h0, 1);
    #1;
    check("sw10_daddr", daddr, 32'h10);
    check("sw10_we", 32'(we), 32'hF);
    check("sw10_dwdata", dwdata, 32'hDEAD_BEEF);
    @(negedge clk);
    idle();

    op("lw10", 1'b0, F3_W, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF, 1);
    op("lb13", 1'b0, F3_B, 32'h13, 32'h0, 1'b0, 32'hFFFF_FFDE, 1);
    op("lbu13", 1'b0, F3_BU, 32'h13, 32'h0, 1'b0, 32'h0000_00DE, 1);
    op("lhu12", 1'b0, F3_HU, 32'h12, 32'h0, 1'b0, 32'h0000_DEAD, 1);
    op("lh12", 1'b0, F3_H, 32'h12, 32'h0, 1'b0, 32'hFFFF_DEAD, 1);
    op("lbu11", 1'b0, F3_BU, 32'h11, 32'h0, 1'b0, 32'h0000_00BE, 1);

    // Word-crossing store split into two memory cycles.
    drive(1'b1, F3_W, 32'h0E, 32'h1122_3344);
    expect_a("sw0e", 1'b0, 32'h0, 2);
    #1;
    check("sw0e_p1_daddr", daddr, 32'h0C);
    check("sw0e_p1_we", 32'(we), 32'hC);
    check("sw0e_p1_dwdata", dwdata, 32'h3344_0000);
    @(negedge clk);
    idle();
    #1;
    check("sw0e_p2_ready", 32'(req_ready), 32'h0);
    check("sw0e_p2_daddr", daddr, 32'h10);
    check("sw0e_p2_we", 32'(we), 32'h3);
    check("sw0e_p2_dwdata", dwdata, 32'h0000_1122);
    @(negedge clk);
    op("lw0e", 1'b0, F3_W, 32'h0E, 32'h0, 1'b0, 32'h1122_3344, 2);
    op("lh11", 1'b0, F3_H, 32'h11, 32'h0, 1'b0, 32'hFFFF_AD11, 1);

    // Error cases: range, bad funct3, store with load-only funct3.
    drive(1'b0, F3_W, 32'h80, 32'h0);
    expect_a("lw80", 1'b1, 32'h0, 1);
    #1;
    check("lw80_we", 32'(we), 32'h0);
    @(negedge clk);
    idle();
    drive(1'b1, F3_H, 32'h7F, 32'h0000_FFFF);
    expect_a("sh7f", 1'b1, 32'h0, 1);
    #1;
    check("sh7f_we", 32'(we), 32'h0);
    @(negedge clk);
    idle();
    op("sb7f", 1'b1, F3_B, 32'h7F, 32'h0000_00A7, 1'b0, 32'h0, 1);
    op("lbu7f", 1'b0, F3_BU, 32'h7F, 32'h0, 1'b0, 32'h0000_00A7, 1);
    op("ld011", 1'b0, 3'b011, 32'h10, 32'h0, 1'b1, 32'h0, 1);
    drive(1'b1, F3_BU, 32'h20, 32'h0000_00FF);
    expect_a("st100", 1'b1, 32'h0, 1);
    #1;
    check("st100_we", 32'(we), 32'h0);
    @(negedge clk);
    idle();

    // Strict instance rejects word-crossing accesses.
    b_req_valid = 1'b1; b_req_we = 1'b0; b_req_funct3 = F3_H; b_req_addr = 32'h03;
    expect_b("b_lh03", 1'b1, 32'h0, 1);
    #1;
    check("b_lh03_we", 32'(b_we), 32'h0);
    @(negedge clk);
    b_req_addr = 32'h02;
    expect_b("b_lh02", 1'b0, 32'hFFFF_8001, 1);
    @(negedge clk);
    b_idle();
    @(negedge clk);

    // Reset during SECOND abandons the phase-2 write.
    op("sw0c", 1'b1, F3_W, 32'h0C, 32'hA5A5_A5A5, 1'b0, 32'h0, 1);
    op("sw10b", 1'b1, F3_W, 32'h10, 32'h5A5A_5A5A, 1'b0, 32'h0, 1);
    drive(1'b1, F3_W, 32'h0E, 32'hCAFE_F00D);
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    #1;
    check("rst2_we", 32'(we), 32'h0);
    check("rst2_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst2_req_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    check("rst2_we_hold", 32'(we), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst2_no_rsp", 32'(rsp_valid), 32'h0);
    op("lw0c", 1'b0, F3_W, 32'h0C, 32'h0, 1'b0, 32'hF00D_A5A5, 1);
    op("lw10c", 1'b0, F3_W, 32'h10, 32'h0, 1'b0, 32'h5A5A_5A5A, 1);

    // Back-to-back aligned store then load.
    drive(1'b1, F3_W, 32'h20, 32'h0BAD_F00D);
    expect_a("sw20", 1'b0, 32'h0, 1);
    #1;
    check("b2b_ready0", 32'(req_ready), 32'h1);
    @(negedge clk);
    drive(1'b0, F3_W, 32'h20, 32'h0);
    expect_a("lw20", 1'b0, 32'h0BAD_F00D, 1);
    #1;
    check("b2b_ready1", 32'(req_ready), 32'h1);
    check("b2b_rsp_overlap", 32'(rsp_valid), 32'h1);
    @(negedge clk);
    idle();

    repeat (3) @(negedge clk);
    check("a_queue_drained", 32'(q_a.size()), 32'h0);
    check("b_queue_drained", 32'(q_b.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
